multiplicador_booth: RTL

- Self-contained, parametrised sequential multiplier with the controller built in.
- Merges the shift-add datapath and its external control FSM into one block with a start/busy/done handshake.
- Adds run-time signed mode (radix-2 Booth, two's complement) alongside unsigned shift-add.
- Sits between the operand source (switch/register bank) and the result display/consumer.

---
 rtl/multiplicador_booth_pkg.sv | 24 ++
 rtl/multiplicador_booth_sumador_restador.sv | 23 ++
 rtl/multiplicador_booth.sv | 163 ++++++++++++++++
 3 files changed

// File: rtl/multiplicador_booth_pkg.sv
// Shared types and constants for the sequential shift-add / Booth multiplier.
// Holds the controller state encoding, the radix-2 Booth pair codes and the
// helper that sizes the iteration counter from the operand width.
package multiplicador_pkg;

    // Controller states: waiting for a request, iterating, reporting the result.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        OPERA = 2'd1,
        FIN   = 2'd2
    } estado_t;

    // Radix-2 Booth decoding of {Q[0], Q_1}. The pair 2'b11 also means
    // "no operation" and is handled by the default branch of the decoder.
    localparam logic [1:0] BOOTH_NOP   = 2'b00;
    localparam logic [1:0] BOOTH_SUMA  = 2'b01;
    localparam logic [1:0] BOOTH_RESTA = 2'b10;

    // Width of a down-counter that must hold the value ancho (not ancho-1).
    function automatic int cont_w(input int ancho);
        return $clog2(ancho + 1);
    endfunction

endpackage

// File: rtl/multiplicador_booth_sumador_restador.sv
// sumador_restador: combinational (ANCHO+1)-bit adder/subtractor.
// resultado = a + b when resta = 0, a - b when resta = 1 (two's complement,
// modulo 2^(ANCHO+1)). Kept standalone so ALU blocks can reuse it.
module sumador_restador #(
    parameter int ANCHO = 8
) (
    input  logic [ANCHO:0] a,
    input  logic [ANCHO:0] b,
    input  logic           resta,
    output logic [ANCHO:0] resultado
);

    logic [ANCHO:0] b_mod;
    logic [ANCHO:0] acarreo_in;

    // Subtraction is a + ~b + 1: invert b and inject the +1 as carry-in.
    always_comb begin
        b_mod      = b ^ {(ANCHO + 1){resta}};
        acarreo_in = {{ANCHO{1'b0}}, resta};
        resultado  = a + b_mod + acarreo_in;
    end

endmodule

// File: rtl/multiplicador_booth.sv
// multiplicador_booth: sequential ANCHO x ANCHO multiplier with built-in
// controller and a start/busy/done handshake.
//   signo = 0 : unsigned shift-add, one partial product per cycle.
//   signo = 1 : radix-2 Booth, two's complement operands and result.
// The accumulator A is ANCHO+1 bits so the extreme cases (max x max unsigned,
// -2^(ANCHO-1) squared signed) never overflow.
// Optional build macro MULT_ZERO_BYPASS_EN: when defined, a zero operand at
// the start request skips the iteration phase and reports 0 straight away.
module multiplicador_booth
    import multiplicador_pkg::*;
#(
    parameter int ANCHO = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 signo,
    input  logic [ANCHO-1:0]     Multiplicando,
    input  logic [ANCHO-1:0]     Multiplicador,
    output logic [2*ANCHO-1:0]   Producto,
    output logic                 busy,
    output logic                 done
);

    localparam int CONT_W = cont_w(ANCHO);

    // Architectural state
    estado_t               estado_reg;
    logic [ANCHO:0]        a_reg;
    logic [ANCHO-1:0]      q_reg;
    logic [ANCHO-1:0]      b_reg;
    logic                  q_1_reg;
    logic [CONT_W-1:0]     p_reg;
    logic                  modo_reg;
    logic [2*ANCHO-1:0]    producto_reg;
    logic                  busy_reg;
    logic                  done_reg;

    // Datapath intermediates
    logic [ANCHO:0]        b_ext;
    logic [ANCHO:0]        operando_b;
    logic                  resta;
    logic [ANCHO:0]        suma;
    logic                  relleno;
    logic [ANCHO:0]        a_next;
    logic [ANCHO-1:0]      q_next;

`ifdef MULT_ZERO_BYPASS_EN
    logic                  operando_cero;

    // A zero operand at the request makes the product trivially zero.
    always_comb begin
        operando_cero = (Multiplicando == '0) || (Multiplicador == '0);
    end
`endif

    // Choose what to add or subtract this iteration.
    always_comb begin
        // Signed mode sign-extends B into the wider accumulator, unsigned zero-extends.
        b_ext      = {(modo_reg & b_reg[ANCHO-1]), b_reg};
        operando_b = '0;
        resta      = 1'b0;
        if (modo_reg) begin
            case ({q_reg[0], q_1_reg})
                BOOTH_SUMA:  operando_b = b_ext;
                BOOTH_RESTA: begin
                    operando_b = b_ext;
                    resta      = 1'b1;
                end
                default:     operando_b = '0;
            endcase
        end else if (q_reg[0]) begin
            operando_b = b_ext;
        end
    end

    sumador_restador #(
        .ANCHO (ANCHO)
    ) u_sumador_restador (
        .a         (a_reg),
        .b         (operando_b),
        .resta     (resta),
        .resultado (suma)
    );

    // Shift {A, Q} right by one after the add. In unsigned mode A never
    // exceeds 2^ANCHO-1 before the add, so the sum fits in ANCHO+1 bits and the
    // carry out of that width is always 0: shifting in 0 is the carry.
    // Signed mode replicates the accumulator sign bit (arithmetic shift).
    always_comb begin
        relleno = modo_reg ? suma[ANCHO] : 1'b0;
        a_next  = {relleno, suma[ANCHO:1]};
        q_next  = {suma[0], q_reg[ANCHO-1:1]};
    end

    // Controller and shift registers: load on request, iterate ANCHO times,
    // latch the product and pulse done for one cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            estado_reg   <= IDLE;
            a_reg        <= '0;
            q_reg        <= '0;
            b_reg        <= '0;
            q_1_reg      <= 1'b0;
            p_reg        <= '0;
            modo_reg     <= 1'b0;
            producto_reg <= '0;
            busy_reg     <= 1'b0;
            done_reg     <= 1'b0;
        end else begin
            done_reg <= 1'b0;
            case (estado_reg)
                IDLE: begin
                    if (start) begin
                        a_reg    <= '0;
                        q_reg    <= Multiplicador;
                        b_reg    <= Multiplicando;
                        q_1_reg  <= 1'b0;
                        p_reg    <= CONT_W'(ANCHO);
                        modo_reg <= signo;
                        busy_reg <= 1'b1;
`ifdef MULT_ZERO_BYPASS_EN
                        if (operando_cero) begin
                            producto_reg <= '0;
                            done_reg     <= 1'b1;
                            estado_reg   <= FIN;
                        end else begin
                            estado_reg   <= OPERA;
                        end
`else
                        estado_reg <= OPERA;
`endif
                    end
                end
                OPERA: begin
                    a_reg   <= a_next;
                    q_reg   <= q_next;
                    q_1_reg <= q_reg[0];
                    p_reg   <= p_reg - CONT_W'(1);
                    if (p_reg == CONT_W'(1)) begin
                        // Last iteration: the shifted pair is the final product.
                        producto_reg <= {a_next[ANCHO-1:0], q_next};
                        done_reg     <= 1'b1;
                        estado_reg   <= FIN;
                    end
                end
                FIN: begin
                    busy_reg   <= 1'b0;
                    estado_reg <= IDLE;
                end
                default: begin
                    busy_reg   <= 1'b0;
                    estado_reg <= IDLE;
                end
            endcase
        end
    end

    assign Producto = producto_reg;
    assign busy     = busy_reg;
    assign done     = done_reg;

endmodule
